// File: rtl/accel_pkg.sv
// ============================================================================
// Package  : accel_pkg
// Brief    : Shared types and constants for the accelerator DMA arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 256;
    localparam int DEF_LEN_W  = 8;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_XFER      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/accel_dma_arbiter_if.sv
// ============================================================================
// Interface: accel_dma_arbiter_if
// Brief    : Requester A/B, DMA engine and status signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accel_dma_arbiter_if
    import accel_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
);
    logic              req_a,   req_b;
    logic [ADDR_W-1:0] addr_a,  addr_b;
    logic [LEN_W-1:0]  len_a,   len_b;
    logic              gnt_a,   gnt_b;
    logic              valid_a, valid_b;
    logic              ready_a, ready_b;
    logic [DATA_W-1:0] data_a,  data_b;
    logic              done_a,  done_b;

    logic              dma_start;
    logic [ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]  dma_len;
    logic              dma_valid;
    logic              dma_ready;
    logic [DATA_W-1:0] dma_data;
    logic              dma_done;

    logic              busy;
    logic              owner;
    logic              err;

    // Arbiter side
    modport slave (
        input  req_a, req_b, addr_a, addr_b, len_a, len_b, ready_a, ready_b,
        input  dma_valid, dma_data, dma_done,
        output gnt_a, gnt_b, valid_a, valid_b, data_a, data_b, done_a, done_b,
        output dma_start, dma_addr, dma_len, dma_ready,
        output busy, owner, err
    );

    // Requester / DMA environment side
    modport master (
        output req_a, req_b, addr_a, addr_b, len_a, len_b, ready_a, ready_b,
        output dma_valid, dma_data, dma_done,
        input  gnt_a, gnt_b, valid_a, valid_b, data_a, data_b, done_a, done_b,
        input  dma_start, dma_addr, dma_len, dma_ready,
        input  busy, owner, err
    );

endinterface

`default_nettype wire

// File: rtl/accel_rr_arb2.sv
// ============================================================================
// Module   : accel_rr_arb2
// Brief    : Two-way round-robin pick; on a tie the previous owner loses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_rr_arb2
    import accel_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_owner,
    output logic grant,
    output logic winner
);

    always_comb begin
        grant  = req_a | req_b;
        winner = OWNER_A;
        if (req_a && req_b) begin
            winner = ~last_owner;
        end else if (req_b) begin
            winner = OWNER_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/accel_dma_arbiter.sv
// ============================================================================
// Module   : accel_dma_arbiter
// Brief    : Arbitrates two requesters onto one DMA burst engine and routes
//            the returned beats to the owner. Build option ACC_ARB_TIMEOUT_EN
//            adds a stall timeout that aborts the burst and sets sticky err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_dma_arbiter
    import accel_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    accel_dma_arbiter_if.slave   bus
);

    localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              done_a_q, done_a_d;
    logic              done_b_q, done_b_d;
    logic              err_q, err_d;

    logic w_req_a, w_req_b, w_grant, w_winner;
    logic w_in_xfer, w_owner_ready, w_dma_ready;
    logic w_hs, w_last_hs, w_abort, w_finish;

    // Zero-length requests never reach arbitration
    assign w_req_a = bus.req_a & (bus.len_a != '0);
    assign w_req_b = bus.req_b & (bus.len_b != '0);

    accel_rr_arb2 u_rr_arb (
        .req_a      (w_req_a),
        .req_b      (w_req_b),
        .last_owner (last_owner_q),
        .grant      (w_grant),
        .winner     (w_winner)
    );

    assign w_in_xfer     = (state_q == ST_XFER);
    assign w_owner_ready = (owner_q == OWNER_B) ? bus.ready_b : bus.ready_a;
    assign w_dma_ready   = w_in_xfer & w_owner_ready;
    assign w_hs          = bus.dma_valid & w_dma_ready;
    assign w_last_hs     = w_hs & (cnt_q == (len_q - C_LEN_ONE));

`ifdef ACC_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = '0;
        w_abort = 1'b0;
        if ((state_q == ST_XFER) || (state_q == ST_WAIT_DONE)) begin
            if (!w_hs) begin
                stall_d = stall_q + STALL_W'(1);
                w_abort = (stall_d == STALL_W'(TIMEOUT));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic unused_timeout;

    assign w_abort        = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        done_a_d     = 1'b0;
        done_b_d     = 1'b0;
        err_d        = err_q;
        w_finish     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant) begin
                    state_d = ST_ISSUE;
                    owner_d = w_winner;
                    addr_d  = (w_winner == OWNER_B) ? bus.addr_b : bus.addr_a;
                    len_d   = (w_winner == OWNER_B) ? bus.len_b  : bus.len_a;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (w_hs) begin
                    cnt_d = cnt_q + C_LEN_ONE;
                end
                // dma_done is only meaningful together with or after the last beat
                if (w_last_hs) begin
                    if (bus.dma_done) begin
                        w_finish = 1'b1;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end else if (w_abort) begin
                    w_finish = 1'b1;
                    err_d    = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.dma_done) begin
                    w_finish = 1'b1;
                end else if (w_abort) begin
                    w_finish = 1'b1;
                    err_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_finish) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
            done_a_d     = (owner_q == OWNER_A);
            done_b_d     = (owner_q == OWNER_B);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            owner_q      <= OWNER_A;
            last_owner_q <= OWNER_B;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            done_a_q     <= done_a_d;
            done_b_q     <= done_b_d;
            err_q        <= err_d;
        end
    end

    assign bus.gnt_a     = (state_q == ST_ISSUE) & (owner_q == OWNER_A);
    assign bus.gnt_b     = (state_q == ST_ISSUE) & (owner_q == OWNER_B);
    assign bus.dma_start = (state_q == ST_ISSUE);
    assign bus.dma_addr  = addr_q;
    assign bus.dma_len   = len_q;
    assign bus.dma_ready = w_dma_ready;

    assign bus.valid_a   = w_in_xfer & (owner_q == OWNER_A) & bus.dma_valid;
    assign bus.valid_b   = w_in_xfer & (owner_q == OWNER_B) & bus.dma_valid;
    assign bus.data_a    = w_in_xfer ? bus.dma_data : '0;
    assign bus.data_b    = w_in_xfer ? bus.dma_data : '0;

    assign bus.done_a    = done_a_q;
    assign bus.done_b    = done_b_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.owner     = owner_q;
    assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_accel_dma_arbiter.sv
// ============================================================================
// Module   : tb_accel_dma_arbiter
// Brief    : Directed and randomized self-checking bench for accel_dma_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_dma_arbiter;
    import accel_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 256;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_last = 1'b1;   // previous owner in the reference model: 1 = B

    always #5 clk = ~clk;

    accel_dma_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    accel_dma_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic clr_in();
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.addr_a = '0;  bus.addr_b = '0;
        bus.len_a = '0;   bus.len_b = '0;
        bus.ready_a = 1'b0; bus.ready_b = 1'b0;
        bus.dma_valid = 1'b0; bus.dma_data = '0; bus.dma_done = 1'b0;
    endtask

    // Feed n back-to-back beats with dma_done on the last one, then expect done for win.
    task automatic serve_simple(input bit win, input int n);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = rnd_data();
            bus.dma_valid = 1'b1; bus.dma_data = d;
            bus.ready_a = 1'b1; bus.ready_b = 1'b1;
            bus.dma_done = (i == n - 1);
            #1;
            chk("ss_valid_owner", win ? bus.valid_b : bus.valid_a, 1'b1);
            chk("ss_valid_other", win ? bus.valid_a : bus.valid_b, 1'b0);
        end
        @(negedge clk);
        clr_in();
        #1;
        chk("ss_done_owner", win ? bus.done_b : bus.done_a, 1'b1);
        chk("ss_done_other", win ? bus.done_a : bus.done_b, 1'b0);
        model_last = win;
    endtask

    // One randomized arbitration + burst, checked against the transaction-level model.
    task automatic rand_burst();
        bit ra, rb, ea, eb, win, hs, fin, done_now;
        int la, lb, need, beats, k;
        logic [ADDR_W-1:0] aa, ab;
        logic [DATA_W-1:0] d;
        logic rdy_w;

        @(negedge clk);
        ra = $urandom_range(0, 1); rb = $urandom_range(0, 1);
        la = $urandom_range(0, 4); lb = $urandom_range(0, 4);
        aa = $urandom();            ab = $urandom();
        bus.req_a = ra; bus.req_b = rb;
        bus.len_a = LEN_W'(la); bus.len_b = LEN_W'(lb);
        bus.addr_a = aa; bus.addr_b = ab;
        ea = ra && (la != 0);
        eb = rb && (lb != 0);

        @(negedge clk);
        clr_in();
        #1;
        if (!(ea || eb)) begin
            chk("rb_ignored_busy", bus.busy, 1'b0);
            chk("rb_ignored_start", bus.dma_start, 1'b0);
            return;
        end
        win  = (ea && eb) ? !model_last : eb;
        need = win ? lb : la;
        chk("rb_gnt_a", bus.gnt_a, !win);
        chk("rb_gnt_b", bus.gnt_b, win);
        chk("rb_start", bus.dma_start, 1'b1);
        chk("rb_addr", bus.dma_addr, win ? ab : aa);
        chk("rb_len", bus.dma_len, LEN_W'(need));
        chk("rb_owner", bus.owner, win);

        beats = 0; fin = 1'b0; done_now = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            d = rnd_data();
            bus.dma_valid = ($urandom_range(0, 3) != 0);
            bus.dma_data  = d;
            bus.ready_a   = $urandom_range(0, 1);
            bus.ready_b   = $urandom_range(0, 1);
            rdy_w = win ? bus.ready_b : bus.ready_a;
            hs    = bus.dma_valid && rdy_w;
            if (hs && (beats == need - 1)) begin
                fin = 1'b1;
                done_now = $urandom_range(0, 1);
                bus.dma_done = done_now;
            end else begin
                bus.dma_done = ($urandom_range(0, 4) == 0);
            end
            #1;
            chk("rb_dma_ready", bus.dma_ready, rdy_w);
            chk("rb_valid_owner", win ? bus.valid_b : bus.valid_a, bus.dma_valid);
            chk("rb_valid_other", win ? bus.valid_a : bus.valid_b, 1'b0);
            chk("rb_data", win ? bus.data_b : bus.data_a, d);
            if (hs) beats++;
        end
        chk("rb_burst_bound", fin, 1'b1);

        if (!done_now) begin
            k = $urandom_range(0, 3);
            for (int c = 0; c < k; c++) begin
                @(negedge clk);
                bus.dma_valid = 1'b1; bus.ready_a = 1'b1; bus.ready_b = 1'b1;
                bus.dma_done = 1'b0;
                #1;
                chk("rb_wait_no_ready", bus.dma_ready, 1'b0);
                chk("rb_wait_busy", bus.busy, 1'b1);
            end
            @(negedge clk);
            clr_in();
            bus.dma_done = 1'b1;
            #1;
            chk("rb_wait_still_busy", bus.busy, 1'b1);
        end
        @(negedge clk);
        clr_in();
        #1;
        chk("rb_done_owner", win ? bus.done_b : bus.done_a, 1'b1);
        chk("rb_done_other", win ? bus.done_a : bus.done_b, 1'b0);
        chk("rb_idle", bus.busy, 1'b0);
        model_last = win;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int va_cnt, hs_cnt;
        bit vb_seen, seen;
        bit rdy_pat [8];

        clr_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_gnt", {bus.gnt_a, bus.gnt_b}, 2'b00);
        chk("reset_start", bus.dma_start, 1'b0);
        chk("reset_done", {bus.done_a, bus.done_b}, 2'b00);
        chk("reset_err", bus.err, 1'b0);
        chk("reset_owner", bus.owner, 1'b0);
        chk("reset_addr", bus.dma_addr, '0);

        // Single A burst of two beats
        @(negedge clk);
        bus.req_a = 1'b1; bus.addr_a = 32'h1000; bus.len_a = 8'd2; bus.ready_a = 1'b1;
        #1;
        chk("r18_start_c0", bus.dma_start, 1'b0);
        @(negedge clk);
        bus.req_a = 1'b0;
        #1;
        chk("r18_start_c1", bus.dma_start, 1'b1);
        chk("r18_gnt_a", bus.gnt_a, 1'b1);
        chk("r18_addr", bus.dma_addr, 32'h1000);
        chk("r18_len", bus.dma_len, 8'd2);
        va_cnt = 0; vb_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d = rnd_data();
            bus.dma_valid = 1'b1; bus.dma_data = d; bus.dma_done = (i == 1);
            #1;
            chk("r18_data_a", bus.data_a, d);
            va_cnt += int'(bus.valid_a);
            vb_seen |= bus.valid_b;
        end
        @(negedge clk);
        clr_in();
        #1;
        chk("r18_done_a", bus.done_a, 1'b1);
        chk("r18_valid_a_count", va_cnt, 2);
        chk("r18_valid_b_never", vb_seen, 1'b0);
        @(negedge clk);
        #1;
        chk("r18_done_one_cycle", bus.done_a, 1'b0);
        model_last = 1'b0;

        // Fresh reset, then simultaneous requests
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        bus.req_a = 1'b1; bus.len_a = 8'd1; bus.req_b = 1'b1; bus.len_b = 8'd1;
        @(negedge clk);
        bus.req_a = 1'b0;
        #1;
        chk("r19_tie_gnt_a", bus.gnt_a, 1'b1);
        chk("r19_tie_gnt_b", bus.gnt_b, 1'b0);
        @(negedge clk);
        bus.dma_valid = 1'b1; bus.ready_a = 1'b1; bus.dma_done = 1'b1;
        #1;
        chk("r19_valid_a", bus.valid_a, 1'b1);
        @(negedge clk);
        bus.dma_valid = 1'b0; bus.dma_done = 1'b0; bus.ready_a = 1'b0;
        #1;
        chk("r19_done_a", bus.done_a, 1'b1);
        chk("r19_b_waits", bus.gnt_b, 1'b0);
        @(negedge clk);
        bus.req_b = 1'b0;
        #1;
        chk("r19_gnt_b_after_done", bus.gnt_b, 1'b1);
        serve_simple(1'b1, 1);
        @(negedge clk);
        bus.req_a = 1'b1; bus.len_a = 8'd1; bus.req_b = 1'b1; bus.len_b = 8'd1;
        @(negedge clk);
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        #1;
        chk("r19_second_tie_a", bus.gnt_a, 1'b1);
        serve_simple(1'b0, 1);

        // Owner back-pressure during a four-beat burst
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        bus.req_a = 1'b1; bus.len_a = 8'd4;
        @(negedge clk);
        bus.req_a = 1'b0;
        #1;
        chk("r20_gnt_a", bus.gnt_a, 1'b1);
        hs_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.dma_valid = 1'b1; bus.ready_a = rdy_pat[i]; bus.dma_data = rnd_data();
            #1;
            chk("r20_dma_ready", bus.dma_ready, (i < 7) ? rdy_pat[i] : 1'b0);
            hs_cnt += int'(bus.dma_valid && bus.dma_ready);
        end
        chk("r20_beat_count", hs_cnt, 4);
        @(negedge clk);
        clr_in();
        bus.dma_done = 1'b1;
        @(negedge clk);
        clr_in();
        #1;
        chk("r20_done_a", bus.done_a, 1'b1);
        model_last = 1'b0;

        // Asynchronous reset in the middle of beat 2
        @(negedge clk);
        bus.req_a = 1'b1; bus.len_a = 8'd4; bus.addr_a = 32'hABCD0000; bus.ready_a = 1'b1;
        @(negedge clk);
        bus.req_a = 1'b0;
        #1;
        chk("r21_gnt_a", bus.gnt_a, 1'b1);
        @(negedge clk);
        bus.dma_valid = 1'b1; bus.dma_data = rnd_data();
        @(negedge clk);
        bus.dma_data = rnd_data();
        #1;
        chk("r21_beat2_valid", bus.valid_a, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("r21_async_busy", bus.busy, 1'b0);
        chk("r21_async_valid", bus.valid_a, 1'b0);
        chk("r21_async_ready", bus.dma_ready, 1'b0);
        chk("r21_async_data", bus.data_a, '0);
        chk("r21_async_addr", bus.dma_addr, '0);
        @(negedge clk);
        clr_in();
        rst = 1'b0;
        model_last = 1'b1;
        #1;
        chk("r21_no_done", bus.done_a, 1'b0);
        @(negedge clk);
        bus.req_a = 1'b1; bus.len_a = 8'd1;
        #1;
        chk("r21_still_no_done", bus.done_a, 1'b0);
        @(negedge clk);
        bus.req_a = 1'b0;
        #1;
        chk("r21_fresh_gnt", bus.gnt_a, 1'b1);
        serve_simple(1'b0, 1);

        // Stalled burst: no beats after start
        @(negedge clk);
        bus.req_a = 1'b1; bus.len_a = 8'd2;
        @(negedge clk);
        bus.req_a = 1'b0;
        #1;
        chk("r22_gnt_a", bus.gnt_a, 1'b1);
`ifdef ACC_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 4 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (bus.done_a) seen = 1'b1;
        end
        chk("r22_timeout_done", seen, 1'b1);
        chk("r22_timeout_err", bus.err, 1'b1);
        chk("r22_timeout_idle", bus.busy, 1'b0);
`else
        seen = 1'b0;
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            @(negedge clk);
            #1;
            if (bus.done_a) seen = 1'b1;
        end
        chk("r22_stall_busy", bus.busy, 1'b1);
        chk("r22_stall_err", bus.err, 1'b0);
        chk("r22_stall_no_done", seen, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        #1;
        chk("r22_err_cleared", bus.err, 1'b0);

        for (int it = 0; it < 40; it++) begin
            rand_burst();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
